// File: rtl/clk_div_scheduler.sv
// Round-robin scheduler that lends one programmable clock divider to NUM_REQ
// requesters, each granted a burst of BURST_LEN full clk_out periods.
module clk_div_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_WIDTH   = 32,
  parameter int BURST_LEN   = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                         clk_in,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] div_value,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         clk_out,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           done
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int PTR_W1 = PTR_W + 1;
  localparam logic [PTR_W:0]         REQ_CNT    = PTR_W1'(NUM_REQ);
  localparam logic [PTR_W-1:0]       OWNER_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]     GRANT_LSB  = NUM_REQ'(1);
  localparam logic [BURST_WIDTH-1:0] TOG_LAST   = BURST_WIDTH'(2 * BURST_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [NUM_REQ-1:0]     grant_reg, grant_next;
  logic [NUM_REQ-1:0]     done_reg, done_next;
  logic                   clk_out_reg, clk_out_next;
  logic [DIV_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [BURST_WIDTH-1:0] tog_reg, tog_next;
  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]       owner_reg, owner_next;
  logic [DIV_WIDTH-1:0]   d_latched_reg, d_latched_next;

  logic [DIV_WIDTH-1:0]   div_arr  [NUM_REQ];
  logic [PTR_W-1:0]       cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]     cand_req;
  logic [PTR_W-1:0]       sel_idx;
  logic                   sel_valid;
  logic [PTR_W-1:0]       rr_ptr_after;

  // Candidate gi is the requester gi places after rr_ptr, so the search order
  // is rotated and a plain lowest-index priority pick gives round robin.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      logic [PTR_W:0] wrapped;
      assign div_arr[gi]  = div_value[gi*DIV_WIDTH +: DIV_WIDTH];
      assign sum          = {1'b0, rr_ptr_reg} + PTR_W1'(gi);
      assign wrapped      = (sum >= REQ_CNT) ? (sum - REQ_CNT) : sum;
      assign cand_idx[gi] = wrapped[PTR_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel_valid = |cand_req;
    sel_idx   = cand_idx[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) sel_idx = cand_idx[k];
    end
  end

  assign rr_ptr_after = (owner_reg == OWNER_LAST) ? '0 : owner_reg + PTR_W'(1);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    done_next      = '0;
    clk_out_next   = clk_out_reg;
    cnt_next       = cnt_reg;
    tog_next       = tog_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    d_latched_next = d_latched_reg;

    case (state_reg)
      IDLE: begin
        clk_out_next = 1'b0;
        cnt_next     = '0;
        tog_next     = '0;
        grant_next   = '0;
        if (sel_valid) begin
          state_next     = RUN;
          grant_next     = GRANT_LSB << sel_idx;
          owner_next     = sel_idx;
          d_latched_next = div_arr[sel_idx];
        end
      end
      RUN: begin
        // A withdrawn request wins over a completion landing on the same cycle.
        if (~|(req & grant_reg)) begin
          state_next   = IDLE;
          grant_next   = '0;
          clk_out_next = 1'b0;
          cnt_next     = '0;
          tog_next     = '0;
          rr_ptr_next  = rr_ptr_after;
        end else if (cnt_reg == d_latched_reg) begin
          cnt_next = '0;
          if (tog_reg == TOG_LAST) begin
            state_next   = IDLE;
            grant_next   = '0;
            done_next    = grant_reg;
            clk_out_next = 1'b0;
            tog_next     = '0;
            rr_ptr_next  = rr_ptr_after;
          end else begin
            clk_out_next = ~clk_out_reg;
            tog_next     = tog_reg + BURST_WIDTH'(1);
          end
        end else begin
          cnt_next = cnt_reg + DIV_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      done_reg      <= '0;
      clk_out_reg   <= 1'b0;
      cnt_reg       <= '0;
      tog_reg       <= '0;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      d_latched_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      clk_out_reg   <= clk_out_next;
      cnt_reg       <= cnt_next;
      tog_reg       <= tog_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      d_latched_reg <= d_latched_next;
    end
  end

  assign grant   = grant_reg;
  assign done    = done_reg;
  assign clk_out = clk_out_reg;
  assign busy    = |grant_reg;

endmodule

// File: doc/clk_div_scheduler.md
# clk_div_scheduler

Shares a single programmable clock-divider datapath among NUM_REQ requesters. Each requester supplies its own divide value and asks for a burst of BURST_LEN full output periods. A round-robin arbiter grants one requester at a time, latches its divide value, runs the divider and reports completion. It sits between the slow-clock consumers (blinkers, sample strobes, test stimulus) and the system clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DIV_WIDTH, 32, width of each divide value and of the internal counter
- BURST_LEN, 8, full clk_out periods generated per grant (>= 1)
- BURST_WIDTH, 8, width of the toggle counter; must hold 2*BURST_LEN
- clk_in  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  level request per requester; held until done or withdrawn
- div_value  input  NUM_REQ*DIV_WIDTH  divide value D of requester i in bits [i*DIV_WIDTH +: DIV_WIDTH]
- grant  output  NUM_REQ  one-hot owner of the divider, all-zero when idle
- clk_out  output  1  divided clock, registered
- busy  output  1  high while a burst is running (grant != 0)
- done  output  NUM_REQ  one-cycle pulse on bit i when requester i's burst completes normally

## Operation
- Divider law: half period = D+1 clk_in cycles; full period = 2*(D+1). D=0 gives clk_out toggling every cycle.
- States: IDLE, RUN.
- IDLE: clk_out=0, counter=0, toggle count=0. If any req bit is high, select the first set bit at or after rr_ptr (wrapping modulo NUM_REQ). Set grant to that one-hot, latch its div_value into d_latched, and go to RUN.
- RUN: the counter increments every cycle. When counter == d_latched, the counter resets to 0, clk_out inverts, and the toggle count increments.
- Normal completion: on the cycle the toggle count reaches 2*BURST_LEN (clk_out returning to 0):
  - go to IDLE and clear grant;
  - pulse done[i];
  - set rr_ptr = (i+1) mod NUM_REQ.
- Abort: if req[i] of the granted requester is low in any RUN cycle:
  - go to IDLE at the next edge;
  - force clk_out to 0 and clear grant;
  - no done pulse;
  - set rr_ptr = (i+1) mod NUM_REQ.
- div_value changes during RUN are ignored. Requests from other requesters during RUN are held off until IDLE.
- Widths: the counter is DIV_WIDTH bits and compared for equality, so it never wraps. The toggle count is BURST_WIDTH bits.

## Timing
- Reset (asynchronous assert, synchronous-edge release) sets:
  - grant=0, clk_out=0, busy=0, done=0;
  - counter=0, toggle count=0, rr_ptr=0, state IDLE.
- Reset asserted mid-burst: outputs go to their reset values immediately, with no done pulse.
- Grant latency:
  - req sampled high at edge t in IDLE → grant and busy visible after edge t.
  - First clk_out rise visible D+1 cycles after grant is first visible.
- Burst duration: 2*BURST_LEN*(D+1) cycles from the first grant-visible cycle to the cycle done is visible.
- At completion, grant drops, done pulses and clk_out falls in the same cycle.
- At least one IDLE cycle separates consecutive grants, so the next grant appears 1 cycle after done.
- Abort: grant and clk_out are 0 one cycle after req drops. No glitch: clk_out only changes on clk_in edges from a flop.
- Simultaneous requests are resolved purely by rr_ptr; a requester that just finished has lowest priority next.

## Test plan
- Reset values: assert resetn low mid-burst (D=2) → grant=0, clk_out=0, busy=0, done=0 immediately; after release, no activity with req=0.
- Single burst: NUM_REQ=4, BURST_LEN=2, req[1]=1, D1=2:
  - grant=4'b0010 one cycle after req;
  - clk_out high/low in 3-cycle phases, 2 periods (12 cycles);
  - done=4'b0010 for one cycle; grant cleared in the same cycle.
- D=0 boundary: BURST_LEN=8 → clk_out toggles every cycle, 8 periods (16 cycles), then done.
- Round robin: req=4'b1111 held, all D=1, BURST_LEN=1 → grants in order 0,1,2,3,0, each separated by one idle cycle.
- Abort: req[2] dropped after 5 cycles of RUN (D=3) → clk_out=0 and grant=0 next cycle, no done; the next grant goes to requester 3 if it is requesting.
- Value latching: change div_value[0] from 2 to 9 mid-burst → all half periods stay 3 cycles; the next grant to requester 0 uses 10-cycle half periods.
